mitchell_antilog_serial: RTL

MITCHELL_ANTILOG_SERIAL -- requirements
Module: mitchell_antilog_serial

---
 rtl/mitchell_antilog_serial.sv | 84 ++++++++
 1 files changed

// File: rtl/mitchell_antilog_serial.sv
// Serial Mitchell antilog: turns a log-domain operand (characteristic k, fraction f)
// into floor({1,f} * 2**k / 2**FRAC_W) using one left shift per cycle.
module mitchell_antilog_serial #(
  parameter int FRAC_W = 7,
  parameter int CHAR_W = 4,
  parameter int OUT_W  = 2 ** CHAR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic              in_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready is high only in IDLE; out_valid rises on entry to DONE and stays high,
  // with out_data stable, until the edge where out_ready is sampled high.

  localparam int WORK_W = FRAC_W + OUT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [WORK_W-1:0]   work;
  logic [CHAR_W-1:0]   count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Hidden leading one sits just above the fraction.
            work  <= in_zero ? '0 : {{(OUT_W-1){1'b0}}, 1'b1, in_frac};
            count <= in_char;
            if (in_zero || (in_char == '0)) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= {work[WORK_W-2:0], 1'b0};
          count <= count - CHAR_W'(1);
          if (count == CHAR_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_data  = work[WORK_W-1:FRAC_W];
  assign dbg_state = state;

endmodule
